// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Bit offset of port `port` within a packed bus of `width`-bit lanes.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register check, write bypass, and the
// data/valid/busy output registers.
module regfile_rd_port #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            busy_next_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_valid_o,
  output logic            rd_busy_o
);

  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_busy_q, rd_busy_d;
  logic            rd_valid_q;

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (rd_en_i) begin
      if (rd_addr_i == '0)
        rd_data_d = '0;
      else if (wr_en_i && (wr_addr_i == rd_addr_i))
        rd_data_d = wr_data_i;
      else
        rd_data_d = rf_data_i;
      rd_busy_d = busy_next_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_busy_o  = rd_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with bypass, zero register,
// busy scoreboard and a sequenced post-reset clear of the storage array.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned  XLEN  = XLEN_DEF,
  parameter int unsigned  NREGS = NREGS_DEF,
  parameter int unsigned  NREAD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_valid,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  init_done
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            init_done_q, init_done_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            run;
  logic            wr_go;

  assign run   = (state_q == ST_RUN);
  assign wr_go = run & wr_en;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (!run) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == AW'(NREGS - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // Clear-then-set: a same-cycle reservation of the written register is a new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_go)
      busy_d[wr_addr] = 1'b0;
    if (run && rsv_en && (rsv_addr != '0))
      busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Storage has no reset; the CLEAR walk zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)
        regs_q[clr_cnt_q] <= '0;
      else if (wr_go && (wr_addr != '0))
        regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    localparam int unsigned AL = port_lsb(p, AW);
    localparam int unsigned DL = port_lsb(p, XLEN);
    logic [AW-1:0] addr;
    assign addr = rd_addr[AL +: AW];

    regfile_rd_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .clk_i       (clk),
      .rst_i       (rst),
      .rd_en_i     (rd_en[p] & run),
      .rd_addr_i   (addr),
      .rf_data_i   (regs_q[addr]),
      .busy_next_i (busy_d[addr]),
      .wr_en_i     (wr_go),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .rd_data_o   (rd_data[DL +: XLEN]),
      .rd_valid_o  (rd_valid[p]),
      .rd_busy_o   (rd_busy[p])
    );
  end

  assign init_done = init_done_q;

endmodule
